serial_sub_n20: RTL and testbench

- Multi-cycle unsigned subtractor for the approximate-arithmetic characterization flow.
- Performs the inverse operation of the 20-bit ripple adder, so adder outputs can be checked round-trip: res = in1 - in2.
- Processes one CHUNK-bit slice per clock and ripples the borrow through a register, trading latency for area.
- Operands arrive and results leave on valid/ready handshakes.

---
 rtl/serial_sub_n20_if.sv | 12 +
 rtl/serial_sub_n20.sv | 55 +++++
 tb/tb_serial_sub_n20.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/serial_sub_n20_if.sv
// serial_sub_n20_if: operand/result valid-ready handshake bundle for the serial subtractor
interface serial_sub_n20_if #(parameter int W = 20);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   res;
  modport master (output in_valid, in1, in2, out_ready, input in_ready, out_valid, res);
  modport slave  (input in_valid, in1, in2, out_ready, output in_ready, out_valid, res);
endinterface

// File: rtl/serial_sub_n20.sv
// serial_sub_n20: multi-cycle unsigned subtractor, one CHUNK-bit slice per clock with registered borrow
module serial_sub_n20 #(
  parameter int W     = 20,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst_n,
  serial_sub_n20_if.slave bus
);
  localparam int NCHUNK = W / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          borrow;
  logic [W-1:0]  a, b;
  logic [W:0]    r;
  logic [CHUNK:0] slice;
  logic          last;
  // Top bit of the CHUNK+1-bit difference is the slice borrow-out
  assign slice = {1'b0, a[cnt*CHUNK +: CHUNK]} - {1'b0, b[cnt*CHUNK +: CHUNK]} - {{CHUNK{1'b0}}, borrow};
  assign last  = cnt == CW'(NCHUNK - 1);
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.res       = r;
  always_comb begin
    state_nx = state;
    if (state == IDLE && bus.in_valid) state_nx = RUN;
    else if (state == RUN && last) state_nx = DONE;
    else if (state == DONE && bus.out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      borrow <= 1'b0;
      a      <= '0;
      b      <= '0;
      r      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.in_valid) begin
        a      <= bus.in1;
        b      <= bus.in2;
        borrow <= 1'b0;
        cnt    <= '0;
      end else if (state == RUN) begin
        r[cnt*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
        borrow <= slice[CHUNK];
        cnt    <= last ? '0 : cnt + 1'b1;
        if (last) r[W] <= slice[CHUNK];
      end
    end
  end
endmodule

// File: tb/tb_serial_sub_n20.sv
// tb_serial_sub_n20: scoreboard bench covering reset, directed borrow cases, backpressure, abort and throughput
module tb_serial_sub_n20;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  serial_sub_n20_if bus ();
  serial_sub_n20 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  logic [20:0] sb[$];

  task automatic apply(input logic [19:0] a, input logic [19:0] b, input logic [20:0] exp);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready); end
    bus.in1 = a; bus.in2 = b; bus.in_valid = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.res} !== {1'b1, 1'b0, 21'h0}) begin
      miscompares++;
      $display("FAIL reset_state in_ready=%b out_valid=%b res=%h required 1 0 000000", bus.in_ready, bus.out_valid, bus.res);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [19:0] ta[6] = '{20'h0000A, 20'h00003, 20'h10000, 20'h00000, 20'hFFFFF, 20'h5A5A5};
    logic [19:0] tb[6] = '{20'h00003, 20'h0000A, 20'h00001, 20'hFFFFF, 20'h00000, 20'h5A5A5};
    logic [20:0] te[6] = '{21'h000007, 21'h1FFFF9, 21'h00FFFF, 21'h100001, 21'h0FFFFF, 21'h000000};
    logic [20:0] exp;
    int n;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply(ta[i], tb[i], te[i]);
      wait_out(n);
      vectors++;
      if (n !== 6) begin miscompares++; $display("FAIL latency_%0d cycles=%0d required=6", i, n); end
      exp = sb.size() ? sb.pop_front() : 'x;
      vectors++;
      if (bus.res !== exp) begin miscompares++; $display("FAIL directed_%0d res=%h required=%h", i, bus.res, exp); end
      vectors++;
      if (bus.res[20] !== (ta[i] < tb[i])) begin miscompares++; $display("FAIL borrow_%0d res20=%b required=%b", i, bus.res[20], ta[i] < tb[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic [20:0] exp;
    int n;
    bus.out_ready = 1'b0;
    apply(20'h12345, 20'h00345, 21'h012000);
    wait_out(n);
    exp = sb.size() ? sb.pop_front() : 'x;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = i[0] ? 1'b0 : 1'b1;
      bus.in1 = 20'h00100 + 20'(i); bus.in2 = 20'h00001;
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.res} !== {1'b1, 1'b0, exp}) begin
        miscompares++;
        $display("FAIL hold_%0d out_valid=%b in_ready=%b res=%h required 1 0 %h", i, bus.out_valid, bus.in_ready, bus.res, exp);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b1; bus.in1 = 20'h00200; bus.in2 = 20'h00050; bus.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.res} !== {1'b0, 1'b1, exp}) begin
      miscompares++;
      $display("FAIL release out_valid=%b in_ready=%b res=%h required 0 1 %h", bus.out_valid, bus.in_ready, bus.res, exp);
    end
    sb.push_back(21'h0001B0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(n);
    exp = sb.size() ? sb.pop_front() : 'x;
    vectors++;
    if (bus.res !== exp) begin miscompares++; $display("FAIL after_release res=%h required=%h", bus.res, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    logic [20:0] exp;
    int n;
    bus.out_ready = 1'b1;
    apply(20'hFFFFF, 20'h12345, 21'h0EDCBA);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.res} !== {1'b1, 1'b0, 21'h0}) begin
      miscompares++;
      $display("FAIL abort in_ready=%b out_valid=%b res=%h required 1 0 000000", bus.in_ready, bus.out_valid, bus.res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply(20'h00010, 20'h00001, 21'h00000F);
    wait_out(n);
    exp = sb.size() ? sb.pop_front() : 'x;
    vectors++;
    if (bus.res !== exp) begin miscompares++; $display("FAIL fresh_op res=%h required=%h", bus.res, exp); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int sent = 0, got = 0, last = 0, cyc = 0;
    logic [19:0] a, b;
    logic [20:0] exp;
    sb.delete();
    bus.out_ready = 1'b1;
    while (got < 1000 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid === 1'b1) begin
        exp = sb.size() ? sb.pop_front() : 'x;
        vectors++;
        if (bus.res !== exp) begin miscompares++; $display("FAIL random_%0d res=%h required=%h", got, bus.res, exp); end
        if (got > 0) begin
          vectors++;
          if (cyc - last !== 7) begin miscompares++; $display("FAIL interval_%0d cycles=%0d required=7", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (bus.in_ready === 1'b1) begin
        if (sent < 1000) begin
          a = 20'($urandom()); b = 20'($urandom());
          bus.in1 = a; bus.in2 = b; bus.in_valid = 1'b1;
          sb.push_back({1'b0, a} - {1'b0, b});
          sent++;
        end else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (got !== 1000) begin miscompares++; $display("FAIL result_count got=%0d required=1000", got); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
